// File: rtl/brisc_pkg.sv
// Shared types and constants for the brisc core, including the data cache.
package brisc_pkg;

    localparam int LINE_BITS   = 128;
    localparam int LINE_BYTES  = LINE_BITS / 8;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    // Default cache geometry used by the packed line type below.
    localparam int DCACHE_ADDR_BITS  = 32;
    localparam int DCACHE_INDEX_BITS = 2;
    localparam int DCACHE_TAG_BITS   = DCACHE_ADDR_BITS - DCACHE_INDEX_BITS - OFFSET_BITS;

    typedef enum logic {
        BYTE = 1'b0,
        WORD = 1'b1
    } data_size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } dcache_state_e;

    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [DCACHE_TAG_BITS-1:0] tag;
        logic [LINE_BITS-1:0]       data;
    } dcache_line_t;

endpackage

// File: rtl/dcache_miss_fsm.sv
// Miss sequencer for the data cache: optional dirty-victim writeback followed
// by a line refill, driving the memory arbiter line interface from registers.
module dcache_miss_fsm
    import brisc_pkg::dcache_state_e, brisc_pkg::IDLE, brisc_pkg::WRITEBACK, brisc_pkg::REFILL;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_BITS     = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     victim_dirty,
    input  logic [ADDRESS_WIDTH-1:0] victim_addr,
    input  logic [LINE_BITS-1:0]     victim_data,
    input  logic [ADDRESS_WIDTH-1:0] refill_addr,
    input  logic                     mem_ack,
    output dcache_state_e            state,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [LINE_BITS-1:0]     mem_wdata,
    output logic                     wb_done,
    output logic                     refill_done
);

    // Refill target captured at miss detection so it survives the writeback
    // even if the requester drops its request meanwhile.
    logic [ADDRESS_WIDTH-1:0] pending_addr;

    // Acks only count while a request is actually outstanding.
    assign wb_done     = mem_req && mem_ack && (state == WRITEBACK);
    assign refill_done = mem_req && mem_ack && (state == REFILL);

    // State register and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            pending_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending_addr <= refill_addr;
                        mem_req      <= 1'b1;
                        if (victim_dirty) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= victim_addr;
                            mem_wdata <= victim_data;
                        end else begin
                            state    <= REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= refill_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        state    <= REFILL;
                        mem_we   <= 1'b0;
                        mem_addr <= pending_addr;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits complete in the request cycle; misses are handed to dcache_miss_fsm.
module dcache
    import brisc_pkg::data_size_e, brisc_pkg::BYTE, brisc_pkg::dcache_state_e, brisc_pkg::IDLE;
#(
    parameter int NUM_LINES     = 4,
    parameter int LINE_BITS     = 128,
    parameter int ADDRESS_WIDTH = 32,
    parameter int XLEN          = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_req,
    input  logic                     store_req,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [XLEN-1:0]          store_data,
    input  data_size_e               data_size,
    output logic [XLEN-1:0]          load_data,
    output logic                     hit,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [LINE_BITS-1:0]     mem_wdata,
    input  logic                     mem_ack,
    input  logic [LINE_BITS-1:0]     mem_rdata
);

    localparam int OFF   = brisc_pkg::OFFSET_BITS;
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAGW  = ADDRESS_WIDTH - OFF - IDX;
    localparam int WSEL  = $clog2(LINE_BITS / XLEN);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAGW-1:0]      tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [IDX-1:0]       idx;
    logic [TAGW-1:0]      req_tag;
    logic [WSEL-1:0]      word_sel;
    logic [1:0]           byte_sel;
    logic                 line_hit;
    logic                 in_idle;
    logic                 store_done;
    logic                 load_done;
    logic                 miss_start;

    logic [LINE_BITS-1:0] cur_line;
    logic [XLEN-1:0]      cur_word;
    logic [7:0]           cur_byte;
    logic [XLEN-1:0]      new_word;
    logic [LINE_BITS-1:0] new_line;

    dcache_state_e            state;
    logic                     wb_done;
    logic                     refill_done;
    logic [IDX-1:0]           fill_idx;
    logic [TAGW-1:0]          fill_tag;
    logic [ADDRESS_WIDTH-1:0] victim_addr;
    logic [ADDRESS_WIDTH-1:0] refill_addr;

    assign idx      = addr[OFF +: IDX];
    assign req_tag  = addr[ADDRESS_WIDTH-1 -: TAGW];
    assign word_sel = addr[2 +: WSEL];
    assign byte_sel = addr[1:0];

    assign in_idle  = (state == IDLE);
    assign line_hit = valid_q[idx] && (tag_q[idx] == req_tag);

    // A store wins over a simultaneous load; the load waits a cycle.
    assign store_done = !reset && store_req && in_idle && line_hit;
    assign load_done  = !reset && load_req && !store_req && in_idle && line_hit;
    assign miss_start = !reset && (load_req || store_req) && in_idle && !line_hit;

    assign hit   = store_done || load_done;
    assign stall = !reset && ((store_req && !store_done) || (load_req && !load_done));

    assign victim_addr = {tag_q[idx], idx, {OFF{1'b0}}};
    assign refill_addr = {req_tag, idx, {OFF{1'b0}}};

    // The refill address sitting on mem_addr names the line being installed.
    assign fill_idx = mem_addr[OFF +: IDX];
    assign fill_tag = mem_addr[ADDRESS_WIDTH-1 -: TAGW];

    // Read the addressed word/byte and build the line image after a store.
    always_comb begin
        int word_base;
        word_base = int'(word_sel) * XLEN;
        cur_line  = data_q[idx];
        cur_word  = cur_line[word_base +: XLEN];
        cur_byte  = cur_word[int'(byte_sel) * 8 +: 8];
        new_word  = cur_word;
        if (data_size == BYTE) begin
            new_word[int'(byte_sel) * 8 +: 8] = store_data[7:0];
        end else begin
            new_word = store_data;
        end
        new_line = cur_line;
        new_line[word_base +: XLEN] = new_word;
    end

    // Load result is only driven for a completing load, zero otherwise.
    always_comb begin
        load_data = '0;
        if (load_done) begin
            if (data_size == BYTE) begin
                load_data = {{(XLEN-8){1'b0}}, cur_byte};
            end else begin
                load_data = cur_word;
            end
        end
    end

    // Valid and dirty bits: refill installs clean, writeback cleans, store dirties.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (refill_done) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wb_done) begin
            dirty_q[fill_idx] <= 1'b0;
        end else if (store_done) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (refill_done) begin
                tag_q[fill_idx]  <= fill_tag;
                data_q[fill_idx] <= mem_rdata;
            end else if (store_done) begin
                data_q[idx] <= new_line;
            end
        end
    end

    dcache_miss_fsm #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .LINE_BITS    (LINE_BITS)
    ) u_miss_fsm (
        .clk         (clk),
        .reset       (reset),
        .start       (miss_start),
        .victim_dirty(valid_q[idx] && dirty_q[idx]),
        .victim_addr (victim_addr),
        .victim_data (cur_line),
        .refill_addr (refill_addr),
        .mem_ack     (mem_ack),
        .state       (state),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .wb_done     (wb_done),
        .refill_done (refill_done)
    );

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: scoreboards for load results and for the
// memory transactions the cache should issue, plus a latency-programmable
// memory model backing the line interface.
module tb_dcache;
    import brisc_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        int          wword;
        logic [31:0] wdata;
    } mem_exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_req;
    logic         store_req;
    logic [31:0]  addr;
    logic [31:0]  store_data;
    data_size_e   data_size;
    logic [31:0]  load_data;
    logic         hit;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int lat    = 3;
    int cnt    = 0;

    logic [31:0]  exp_load[$];
    mem_exp_t     exp_mem[$];
    logic [127:0] backing[logic [31:0]];

    always #5 clk = ~clk;

    dcache #(
        .NUM_LINES    (4),
        .LINE_BITS    (128),
        .ADDRESS_WIDTH(32),
        .XLEN         (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .store_req (store_req),
        .addr      (addr),
        .store_data(store_data),
        .data_size (data_size),
        .load_data (load_data),
        .hit       (hit),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] genLine(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i*32 +: 32] = {a[15:0], 16'(16'hC000 + i)};
        end
        return l;
    endfunction

    function automatic logic [127:0] readLine(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return genLine(a);
    endfunction

    function automatic mem_exp_t mkExp(input logic [31:0] a, input logic we, input int wword, input logic [31:0] wdata);
        mem_exp_t e;
        e.addr  = a;
        e.we    = we;
        e.wword = wword;
        e.wdata = wdata;
        return e;
    endfunction

    // Memory model: checks each new transaction on its first cycle and acks
    // after 'lat' further cycles of mem_req.
    initial begin
        mem_exp_t e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset || !mem_req) begin
                cnt     = 0;
                mem_ack = 1'b0;
            end else begin
                cnt++;
                mem_ack = 1'b0;
                if (cnt == 1) begin
                    checkOutput("mem_txn_expected", 32'(exp_mem.size() != 0), 32'd1);
                    if (exp_mem.size() != 0) begin
                        e = exp_mem.pop_front();
                        checkOutput("mem_addr", mem_addr, e.addr);
                        checkOutput("mem_we", 32'(mem_we), 32'(e.we));
                        if (e.we) checkOutput("mem_wdata_word", mem_wdata[e.wword*32 +: 32], e.wdata);
                    end
                end
                if (cnt > lat) begin
                    mem_ack = 1'b1;
                    cnt     = 0;
                    if (mem_we) backing[mem_addr] = mem_wdata;
                    else        mem_rdata = readLine(mem_addr);
                end
            end
        end
    end

    task automatic applyStimulus(input bit is_store, input logic [31:0] a, input data_size_e sz,
                                 input logic [31:0] d, input logic [31:0] exp_data,
                                 input int exp_stalls, input string tag);
        int   stalls = 0;
        bit   done   = 1'b0;
        logic [31:0] e;
        @(posedge clk);
        #1;
        load_req   = !is_store;
        store_req  = is_store;
        addr       = a;
        data_size  = sz;
        store_data = d;
        if (!is_store) exp_load.push_back(exp_data);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (hit && !stall) done = 1'b1;
            else if (stall) stalls++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        if (!is_store) begin
            e = exp_load.pop_front();
            if (done) checkOutput({tag, "_data"}, load_data, e);
        end
        checkOutput({tag, "_stalls"}, stalls, exp_stalls);
        @(posedge clk);
        #1;
        load_req  = 1'b0;
        store_req = 1'b0;
    endtask

    initial begin
        logic [127:0] l40;
        l40 = genLine(32'h40);
        l40[31:0] = 32'hDEAD_BEEF;
        backing[32'h40] = l40;

        reset      = 1'b1;
        load_req   = 1'b0;
        store_req  = 1'b0;
        addr       = '0;
        store_data = '0;
        data_size  = WORD;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_load_data", load_data, 32'd0);
        checkOutput("rst_hit", 32'(hit), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata[31:0], 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Cold load miss, clean refill
        exp_mem.push_back(mkExp(32'h40, 1'b0, 0, 32'd0));
        applyStimulus(1'b0, 32'h40, WORD, 32'd0, 32'hDEAD_BEEF, 5, "cold_load");

        // Store hits and word/byte loads
        applyStimulus(1'b1, 32'h44, WORD, 32'h1234_5678, 32'd0, 0, "st_word");
        applyStimulus(1'b0, 32'h44, WORD, 32'd0, 32'h1234_5678, 0, "ld_word");
        applyStimulus(1'b1, 32'h45, BYTE, 32'h0000_00AB, 32'd0, 0, "st_byte");
        applyStimulus(1'b0, 32'h45, BYTE, 32'd0, 32'h0000_00AB, 0, "ld_byte45");
        applyStimulus(1'b0, 32'h44, WORD, 32'd0, 32'h1234_AB78, 0, "ld_merged");
        applyStimulus(1'b0, 32'h47, BYTE, 32'd0, 32'h0000_0012, 0, "ld_byte47");

        // Conflict miss with dirty victim, then re-fetch of the written-back line
        exp_mem.push_back(mkExp(32'h40, 1'b1, 1, 32'h1234_AB78));
        exp_mem.push_back(mkExp(32'h80, 1'b0, 0, 32'd0));
        applyStimulus(1'b0, 32'h80, WORD, 32'd0, 32'h0080_C000, 9, "evict_load");
        exp_mem.push_back(mkExp(32'h40, 1'b0, 0, 32'd0));
        applyStimulus(1'b0, 32'h44, WORD, 32'd0, 32'h1234_AB78, 5, "refetch");

        // Simultaneous store and load, both hitting
        exp_load.push_back(32'h5566_7788);
        @(posedge clk);
        #1;
        store_req  = 1'b1;
        load_req   = 1'b1;
        addr       = 32'h48;
        data_size  = WORD;
        store_data = 32'h5566_7788;
        @(negedge clk);
        checkOutput("dual_hit", 32'(hit), 32'd1);
        checkOutput("dual_load_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1 store_req = 1'b0;
        @(negedge clk);
        checkOutput("dual_load_hit", 32'(hit), 32'd1);
        checkOutput("dual_load_nostall", 32'(stall), 32'd0);
        checkOutput("dual_load_data", load_data, exp_load.pop_front());
        @(posedge clk);
        #1 load_req = 1'b0;

        // Store miss into a cold line (write-allocate)
        exp_mem.push_back(mkExp(32'h10, 1'b0, 0, 32'd0));
        applyStimulus(1'b1, 32'h13, BYTE, 32'h0000_005A, 32'd0, 5, "st_miss");
        applyStimulus(1'b0, 32'h13, BYTE, 32'd0, 32'h0000_005A, 0, "ld_st_miss_b");
        applyStimulus(1'b0, 32'h10, WORD, 32'd0, 32'h5A10_C000, 0, "ld_st_miss_w");

        // Request dropped during a miss: refill still completes
        exp_mem.push_back(mkExp(32'h20, 1'b0, 0, 32'd0));
        @(posedge clk);
        #1;
        load_req  = 1'b1;
        addr      = 32'h24;
        data_size = WORD;
        @(negedge clk);
        checkOutput("flush_miss_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1 load_req = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("flush_mem_idle", 32'(mem_req), 32'd0);
        checkOutput("flush_no_stall", 32'(stall), 32'd0);
        applyStimulus(1'b0, 32'h24, WORD, 32'd0, 32'h0020_C001, 0, "flush_hit");

        // Reset during refill abandons the miss and invalidates every line
        lat = 50;
        exp_mem.push_back(mkExp(32'h30, 1'b0, 0, 32'd0));
        @(posedge clk);
        #1;
        load_req = 1'b1;
        addr     = 32'h38;
        repeat (3) @(negedge clk);
        checkOutput("rst_mid_req", 32'(mem_req), 32'd1);
        checkOutput("rst_mid_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        load_req = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_abandon_req", 32'(mem_req), 32'd0);
        checkOutput("rst_abandon_stall", 32'(stall), 32'd0);
        lat = 3;
        exp_mem.push_back(mkExp(32'h40, 1'b0, 0, 32'd0));
        applyStimulus(1'b0, 32'h40, WORD, 32'd0, 32'hDEAD_BEEF, 5, "post_rst_load");

        checkOutput("mem_queue_empty", 32'(exp_mem.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
